pe_array_ctrl: RTL and testbench
================================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter ROWS, default 8, number of PE rows.
REQ-002 Parameter COLS, default 8, number of PE columns.
REQ-003 Parameter GEN_BITS, default 16, width of generation counters.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 load_start  in  1  request to load a full pattern.
REQ-007 load_data  in  PE_STATE_BITS  cell state, row-major order.
REQ-008 load_valid / load_ready  in / out  1 each  load beat handshake.
REQ-009 run_start  in  1  request to run run_gens generations.
REQ-010 run_gens  in  GEN_BITS  generation count, sampled on run_start.
REQ-011 read_start  in  1  request to read the full array out.
REQ-012 rd_data  out  PE_STATE_BITS  cell state, row-major order.
REQ-013 rd_valid / rd_ready  out / in  1 each  readout beat handshake.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of each load, run or read.
REQ-016 gen_count  out  GEN_BITS  PROCESS commands issued in the current or last run.
REQ-017 cmd  out  PE_CMD_BITS  broadcast PE command.
REQ-018 rsel_i / csel_i  out  ROWS / COLS  one-hot write selects.
REQ-019 rsel_o / csel_o  out  ROWS / COLS  one-hot read selects.
REQ-020 state_in  out  PE_STATE_BITS  broadcast write data.
REQ-021 array_state_out  in  PE_STATE_BITS  OR of all PE state_out values (unselected PEs drive 0).
REQ-022 array_active  in  1  OR of all PE active outputs.

Function
REQ-023 FSM states: IDLE, LOAD, RUN, READ; starts are honoured only in IDLE, with priority load > run > read, and are ignored elsewhere.
REQ-024 LOAD: load_ready=1; each load_valid&load_ready beat drives cmd=PE_CMD_WRITE, the one-hot rsel_i/csel_i of the current cell and state_in=load_data in that same cycle, then advances the cell index.
REQ-025 In LOAD, cycles without a beat drive cmd=PE_CMD_NOP with selects zero.
REQ-026 LOAD exits to IDLE with done after beat ROWS*COLS; the index wraps column-first, then row.
REQ-027 RUN: gen_count clears on entry, then cmd=PE_CMD_PROCESS for one cycle per generation, with gen_count incrementing each cycle.
REQ-028 RUN exits to IDLE with done when gen_count reaches run_gens; run_gens=0 returns to IDLE with done in the next cycle and no PROCESS.
REQ-029 READ: drive rsel_o/csel_o one-hot for the current cell; rd_valid=1; rd_data=array_state_out (combinational); advance on rd_valid&rd_ready; exit to IDLE with done after the last beat.
REQ-030 Outside active beats cmd=PE_CMD_NOP, and all selects, state_in and rd_data are 0.
REQ-031 gen_count holds its value in IDLE, and saturates at all-ones.

Reset
REQ-032 On rst: state IDLE, cmd=PE_CMD_NOP, all selects 0, state_in 0, load_ready/rd_valid/busy/done 0, gen_count 0, cell index 0.
REQ-033 rst mid-operation aborts immediately with no further WRITE or PROCESS issued; a partial load is not resumed.

Configuration
REQ-034 With PE_CTRL_EARLY_STOP_EN defined, a PROCESS cycle with array_active=0 ends RUN after that cycle, with done asserted and gen_count including that cycle.
REQ-035 Without PE_CTRL_EARLY_STOP_EN, array_active is ignored and RUN always issues exactly run_gens PROCESS commands.

Structure
REQ-036 Package pe_ctrl_pkg holds the FSM state enum and the ROWS*COLS cell-count helper; PE_CMD_* and PE_STATE_* encodings come from pe_decs.sv.
REQ-037 One sub-module, pe_scan_ctr, holds the row/column counters with wrap, a last-cell flag and one-hot decode; LOAD and READ share it.

Verification
REQ-038 4x4 array: load the glider pattern in 16 beats with a load_valid gap at beat 5 -> 16 WRITE cycles, correct one-hot selects, NOP in the gap, done on beat 16.
REQ-039 run_gens=4 on the glider -> exactly 4 PROCESS cycles, gen_count=4, and readout shows the glider shifted by (1,1).
REQ-040 Read with rd_ready toggling 1,0,1,... -> 16 beats in row-major order, with selects and rd_data held while rd_ready=0.
REQ-041 Load a 2x2 block then run_gens=10 -> with EARLY_STOP_EN, gen_count=1 and done after 1 PROCESS; without it, gen_count=10.
REQ-042 rst asserted at load beat 7 -> next cycle IDLE, cmd NOP, load_ready 0; run_start while busy is ignored.
REQ-043 load_start and run_start in the same cycle -> LOAD entered; run_gens=0 -> done one cycle after run_start with no PROCESS.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Controller-local types: FSM state encoding and array sizing helpers.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_READ = 2'd3
    } pe_ctrl_state_e;

    function automatic int cell_count(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Index width that stays legal for a single-entry dimension.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_decs.sv
// Shared PE command and cell-state encodings used by the controller and the PE array.
package pe_decs;

    localparam int PE_CMD_BITS = 2;
    localparam logic [PE_CMD_BITS-1:0] PE_CMD_NOP     = 2'd0;
    localparam logic [PE_CMD_BITS-1:0] PE_CMD_WRITE   = 2'd1;
    localparam logic [PE_CMD_BITS-1:0] PE_CMD_PROCESS = 2'd2;

    localparam int PE_STATE_BITS = 1;
    localparam logic [PE_STATE_BITS-1:0] PE_STATE_DEAD  = 1'b0;
    localparam logic [PE_STATE_BITS-1:0] PE_STATE_ALIVE = 1'b1;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Host-side command and data port of pe_array_ctrl; GEN_BITS must match the controller.
interface pe_array_ctrl_if
    import pe_decs::*;
#(
    parameter int GEN_BITS = 16
);

    // A beat transfers on a rising clk edge where valid && ready are both high;
    // the sender holds data stable while valid is high and ready is low.
    logic                     load_start;
    logic [PE_STATE_BITS-1:0] load_data;
    logic                     load_valid;
    logic                     load_ready;

    logic                     run_start;
    logic [GEN_BITS-1:0]      run_gens;

    logic                     read_start;
    logic [PE_STATE_BITS-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_ready;

    modport master (
        output load_start, load_data, load_valid, run_start, run_gens, read_start, rd_ready,
        input  load_ready, rd_data, rd_valid
    );

    modport slave (
        input  load_start, load_data, load_valid, run_start, run_gens, read_start, rd_ready,
        output load_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/pe_scan_ctr.sv
// Row-major cell scanner shared by array load and readout: column wraps first, then row.
module pe_scan_ctr
    import pe_ctrl_pkg::*;
#(
    parameter int  ROWS      = 8,
    parameter int  COLS      = 8,
    localparam int CELL_BITS = idx_bits(cell_count(ROWS, COLS))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 adv,
    output logic                 last,
    output logic [ROWS-1:0]      row_oh,
    output logic [COLS-1:0]      col_oh,
    output logic [CELL_BITS-1:0] cell_idx
);

    localparam int RB = idx_bits(ROWS);
    localparam int CB = idx_bits(COLS);

    logic [RB-1:0]        row_q, row_d;
    logic [CB-1:0]        col_q, col_d;
    logic [CELL_BITS-1:0] cell_q, cell_d;
    logic                 row_last;
    logic                 col_last;

    assign row_last = (row_q == RB'(ROWS - 1));
    assign col_last = (col_q == CB'(COLS - 1));
    assign last     = row_last && col_last;
    assign cell_idx = cell_q;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        cell_d = cell_q;
        if (clr) begin
            row_d  = '0;
            col_d  = '0;
            cell_d = '0;
        end else if (adv) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            cell_d = last ? '0 : cell_q + 1'b1;
        end
    end

    always_comb begin
        row_oh = '0;
        col_oh = '0;
        for (int i = 0; i < ROWS; i++) begin
            row_oh[i] = (row_q == RB'(i));
        end
        for (int j = 0; j < COLS; j++) begin
            col_oh[j] = (col_q == CB'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            cell_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            cell_q <= cell_d;
        end
    end

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for a ROWS x COLS PE array: pattern load, generation run and readout.
// Define PE_CTRL_EARLY_STOP_EN to end a run on the first PROCESS cycle with array_active low.
module pe_array_ctrl
    import pe_decs::*;
    import pe_ctrl_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int GEN_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    pe_array_ctrl_if.slave           host,
    output logic                     busy,
    output logic                     done,
    output logic [GEN_BITS-1:0]      gen_count,
    output logic [PE_CMD_BITS-1:0]   cmd,
    output logic [ROWS-1:0]          rsel_i,
    output logic [COLS-1:0]          csel_i,
    output logic [ROWS-1:0]          rsel_o,
    output logic [COLS-1:0]          csel_o,
    output logic [PE_STATE_BITS-1:0] state_in,
    input  logic [PE_STATE_BITS-1:0] array_state_out,
    input  logic                     array_active,
    output pe_ctrl_state_e           dbg_state,
    output logic [idx_bits(cell_count(ROWS, COLS))-1:0] dbg_cell
);

    pe_ctrl_state_e      state_q, state_d;
    logic [GEN_BITS-1:0] gen_q, gen_d;
    logic [GEN_BITS-1:0] tgt_q, tgt_d;
    logic [GEN_BITS-1:0] gen_inc;
    logic                stop_early;

    logic                scan_clr;
    logic                scan_adv;
    logic                scan_last;
    logic [ROWS-1:0]     scan_row_oh;
    logic [COLS-1:0]     scan_col_oh;

    pe_scan_ctr #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .clr      (scan_clr),
        .adv      (scan_adv),
        .last     (scan_last),
        .row_oh   (scan_row_oh),
        .col_oh   (scan_col_oh),
        .cell_idx (dbg_cell)
    );

`ifdef PE_CTRL_EARLY_STOP_EN
    assign stop_early = ~array_active;
`else
    logic unused_active;
    assign unused_active = array_active;
    assign stop_early    = 1'b0;
`endif

    // The counter sticks at all-ones instead of wrapping back to zero.
    assign gen_inc   = (&gen_q) ? gen_q : gen_q + 1'b1;
    assign gen_count = gen_q;
    assign dbg_state = state_q;
    assign busy      = ~rst && (state_q != ST_IDLE);

    always_comb begin
        state_d         = state_q;
        gen_d           = gen_q;
        tgt_d           = tgt_q;
        cmd             = PE_CMD_NOP;
        rsel_i          = '0;
        csel_i          = '0;
        rsel_o          = '0;
        csel_o          = '0;
        state_in        = '0;
        host.load_ready = 1'b0;
        host.rd_valid   = 1'b0;
        host.rd_data    = '0;
        done            = 1'b0;
        scan_clr        = 1'b0;
        scan_adv        = 1'b0;
        // While rst is high every output is quiet, so an abort issues nothing further.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (host.load_start) begin
                        state_d  = ST_LOAD;
                        scan_clr = 1'b1;
                    end else if (host.run_start) begin
                        state_d = ST_RUN;
                        gen_d   = '0;
                        tgt_d   = host.run_gens;
                    end else if (host.read_start) begin
                        state_d  = ST_READ;
                        scan_clr = 1'b1;
                    end
                end
                ST_LOAD: begin
                    host.load_ready = 1'b1;
                    if (host.load_valid) begin
                        cmd      = PE_CMD_WRITE;
                        rsel_i   = scan_row_oh;
                        csel_i   = scan_col_oh;
                        state_in = host.load_data;
                        scan_adv = 1'b1;
                        if (scan_last) begin
                            done    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    // Only a zero-generation run reaches RUN with the target already met.
                    if (gen_q == tgt_q) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cmd   = PE_CMD_PROCESS;
                        gen_d = gen_inc;
                        if ((gen_inc == tgt_q) || stop_early) begin
                            done    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    host.rd_valid = 1'b1;
                    rsel_o        = scan_row_oh;
                    csel_o        = scan_col_oh;
                    host.rd_data  = array_state_out;
                    if (host.rd_ready) begin
                        scan_adv = 1'b1;
                        if (scan_last) begin
                            done    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gen_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl on a 4x4 array backed by a Game-of-Life PE model.
module tb_pe_array_ctrl;
    import pe_decs::*;
    import pe_ctrl_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int GB   = 16;

    // Row-major, bit r*4+c: glider, the same glider after 4 generations, 2x2 block.
    localparam logic [15:0] GLIDER   = 16'h0742;
    localparam logic [15:0] GLIDER_4 = 16'hE840;
    localparam logic [15:0] BLOCK    = 16'h0660;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_array_ctrl_if #(.GEN_BITS(GB)) host ();

    logic                     busy;
    logic                     done;
    logic [GB-1:0]            gen_count;
    logic [PE_CMD_BITS-1:0]   cmd;
    logic [ROWS-1:0]          rsel_i, rsel_o;
    logic [COLS-1:0]          csel_i, csel_o;
    logic [PE_STATE_BITS-1:0] state_in;
    logic [PE_STATE_BITS-1:0] array_state_out;
    logic                     array_active;
    pe_ctrl_state_e           dbg_state;
    logic [3:0]               dbg_cell;

    pe_array_ctrl #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .GEN_BITS (GB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host            (host),
        .busy            (busy),
        .done            (done),
        .gen_count       (gen_count),
        .cmd             (cmd),
        .rsel_i          (rsel_i),
        .csel_i          (csel_i),
        .rsel_o          (rsel_o),
        .csel_o          (csel_o),
        .state_in        (state_in),
        .array_state_out (array_state_out),
        .array_active    (array_active),
        .dbg_state       (dbg_state),
        .dbg_cell        (dbg_cell)
    );

    // PE array model: cells outside the 4x4 grid count as dead.
    logic [15:0] cells = '0;
    logic [15:0] sel_mask;
    int          n_write = 0;
    int          n_proc  = 0;

    function automatic logic [15:0] life_step(input logic [15:0] g);
        logic [15:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
                            if (g[rr*4+cc]) cnt++;
                    end
                end
                n[r*4+c] = g[r*4+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb begin
        sel_mask = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sel_mask[r*4+c] = rsel_o[r] & csel_o[c];
    end

    assign array_state_out = |(cells & sel_mask);
    assign array_active    = (life_step(cells) != cells);

    always @(posedge clk) begin
        if (cmd == PE_CMD_WRITE) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (rsel_i[r] && csel_i[c]) cells[r*4+c] <= state_in[0];
            n_write <= n_write + 1;
        end else if (cmd == PE_CMD_PROCESS) begin
            cells  <= life_step(cells);
            n_proc <= n_proc + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_pattern(input logic [15:0] p);
        @(negedge clk);
        host.load_start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            host.load_start = 1'b0;
            host.load_valid = 1'b1;
            host.load_data  = p[k];
        end
        @(negedge clk);
        host.load_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        int          k;
        int          w0, p0, exp_n;

        host.load_start = 1'b0;
        host.load_data  = '0;
        host.load_valid = 1'b0;
        host.run_start  = 1'b0;
        host.run_gens   = '0;
        host.read_start = 1'b0;
        host.rd_ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_cmd", 32'(cmd), 32'(PE_CMD_NOP));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load_ready", 32'(host.load_ready), 32'd0);
        check("rst_rd_valid", 32'(host.rd_valid), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        check("rst_sel", 32'({rsel_i, csel_i, rsel_o, csel_o, state_in}), 32'd0);
        check("rst_cell", 32'(dbg_cell), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Glider load, one idle cycle before the fifth beat
        pat = GLIDER;
        @(negedge clk);
        host.load_start = 1'b1;
        #1;
        check("load_start_idle_busy", 32'(busy), 32'd0);
        w0 = n_write;
        k  = 0;
        for (int t = 0; t < 17; t++) begin
            @(negedge clk);
            host.load_start = 1'b0;
            host.load_valid = (t != 4);
            host.load_data  = pat[k];
            #1;
            check($sformatf("load_ready[%0d]", t), 32'(host.load_ready), 32'd1);
            if (t == 4) begin
                check("gap_cmd", 32'(cmd), 32'(PE_CMD_NOP));
                check("gap_sel", 32'({rsel_i, csel_i, state_in}), 32'd0);
                check("gap_done", 32'(done), 32'd0);
            end else begin
                check($sformatf("load_cmd[%0d]", k), 32'(cmd), 32'(PE_CMD_WRITE));
                check($sformatf("load_rsel[%0d]", k), 32'(rsel_i), 32'(1 << (k / 4)));
                check($sformatf("load_csel[%0d]", k), 32'(csel_i), 32'(1 << (k % 4)));
                check($sformatf("load_data[%0d]", k), 32'(state_in), 32'(pat[k]));
                check($sformatf("load_done[%0d]", k), 32'(done), 32'(k == 15));
                k++;
            end
        end
        @(negedge clk);
        host.load_valid = 1'b0;
        #1;
        check("load_end_state", 32'(dbg_state), 32'(ST_IDLE));
        check("load_end_ready", 32'(host.load_ready), 32'd0);
        check("load_write_count", 32'(n_write - w0), 32'd16);
        check("load_cells", 32'(cells), 32'(GLIDER));

        // Run 4 generations
        @(negedge clk);
        host.run_start = 1'b1;
        host.run_gens  = 16'd4;
        #1;
        p0 = n_proc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            host.run_start = 1'b0;
            #1;
            check($sformatf("run_cmd[%0d]", i), 32'(cmd), 32'(PE_CMD_PROCESS));
            check($sformatf("run_gen[%0d]", i), 32'(gen_count), 32'(i));
            check($sformatf("run_done[%0d]", i), 32'(done), 32'(i == 3));
            check($sformatf("run_busy[%0d]", i), 32'(busy), 32'd1);
        end
        @(negedge clk);
        #1;
        check("run_end_state", 32'(dbg_state), 32'(ST_IDLE));
        check("run_end_cmd", 32'(cmd), 32'(PE_CMD_NOP));
        check("run_gen_final", 32'(gen_count), 32'd4);
        check("run_proc_count", 32'(n_proc - p0), 32'd4);
        check("run_cells", 32'(cells), 32'(GLIDER_4));
        @(negedge clk);
        #1;
        check("gen_hold_idle", 32'(gen_count), 32'd4);

        // Readout with rd_ready alternating 1,0,1,...
        pat = GLIDER_4;
        @(negedge clk);
        host.read_start = 1'b1;
        k = 0;
        for (int t = 0; t < 31; t++) begin
            @(negedge clk);
            host.read_start = 1'b0;
            host.rd_ready   = (t % 2 == 0);
            #1;
            check($sformatf("rd_valid[%0d]", t), 32'(host.rd_valid), 32'd1);
            check($sformatf("rd_rsel[%0d]", t), 32'(rsel_o), 32'(1 << (k / 4)));
            check($sformatf("rd_csel[%0d]", t), 32'(csel_o), 32'(1 << (k % 4)));
            check($sformatf("rd_data[%0d]", t), 32'(host.rd_data), 32'(pat[k]));
            check($sformatf("rd_done[%0d]", t), 32'(done), 32'((t % 2 == 0) && k == 15));
            if (t % 2 == 0) k++;
        end
        @(negedge clk);
        host.rd_ready = 1'b0;
        #1;
        check("rd_end_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rd_end_valid", 32'(host.rd_valid), 32'd0);
        check("rd_end_quiet", 32'({rsel_o, csel_o, host.rd_data}), 32'd0);

        // Still-life block, 10 generations requested
        load_pattern(BLOCK);
        check("block_cells", 32'(cells), 32'(BLOCK));
`ifdef PE_CTRL_EARLY_STOP_EN
        exp_n = 1;
`else
        exp_n = 10;
`endif
        @(negedge clk);
        host.run_start = 1'b1;
        host.run_gens  = 16'd10;
        #1;
        p0 = n_proc;
        for (int i = 0; i < exp_n; i++) begin
            @(negedge clk);
            host.run_start = 1'b0;
            #1;
            check($sformatf("blk_cmd[%0d]", i), 32'(cmd), 32'(PE_CMD_PROCESS));
            check($sformatf("blk_done[%0d]", i), 32'(done), 32'(i == exp_n - 1));
        end
        @(negedge clk);
        #1;
        check("blk_end_state", 32'(dbg_state), 32'(ST_IDLE));
        check("blk_gen", 32'(gen_count), 32'(exp_n));
        check("blk_proc_count", 32'(n_proc - p0), 32'(exp_n));

        // load_start and run_start together: load wins; run_start while busy is ignored
        @(negedge clk);
        host.load_start = 1'b1;
        host.run_start  = 1'b1;
        host.run_gens   = 16'd5;
        #1;
        p0 = n_proc;
        @(negedge clk);
        host.load_start = 1'b0;
        host.load_valid = 1'b1;
        host.load_data  = 1'b1;
        #1;
        check("prio_state", 32'(dbg_state), 32'(ST_LOAD));
        check("prio_cmd", 32'(cmd), 32'(PE_CMD_WRITE));
        check("prio_sel", 32'({rsel_i, csel_i}), 32'h11);
        for (int b = 1; b < 6; b++) begin
            @(negedge clk);
            host.run_start = 1'b0;
            #1;
            check($sformatf("busy_load_state[%0d]", b), 32'(dbg_state), 32'(ST_LOAD));
        end
        // Reset lands on the seventh beat
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        host.load_valid = 1'b0;
        #1;
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_cmd", 32'(cmd), 32'(PE_CMD_NOP));
        check("abort_ready", 32'(host.load_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cell", 32'(dbg_cell), 32'd0);
        check("abort_no_process", 32'(n_proc - p0), 32'd0);

        // A fresh load starts from cell 0
        @(negedge clk);
        host.load_start = 1'b1;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            host.load_start = 1'b0;
            host.load_valid = 1'b1;
            host.load_data  = 1'b0;
            #1;
            if (b == 0) begin
                check("reload_first_sel", 32'({rsel_i, csel_i}), 32'h11);
                check("reload_first_cell", 32'(dbg_cell), 32'd0);
            end
            if (b == 15) check("reload_done", 32'(done), 32'd1);
        end

        // Zero-generation run
        @(negedge clk);
        host.load_valid = 1'b0;
        host.run_start  = 1'b1;
        host.run_gens   = '0;
        #1;
        p0 = n_proc;
        @(negedge clk);
        host.run_start = 1'b0;
        #1;
        check("zero_state", 32'(dbg_state), 32'(ST_RUN));
        check("zero_done", 32'(done), 32'd1);
        check("zero_cmd", 32'(cmd), 32'(PE_CMD_NOP));
        @(negedge clk);
        #1;
        check("zero_end_state", 32'(dbg_state), 32'(ST_IDLE));
        check("zero_end_done", 32'(done), 32'd0);
        check("zero_gen", 32'(gen_count), 32'd0);
        check("zero_no_process", 32'(n_proc - p0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
